// File: rtl/seq_pkg.sv
// Shared types, decoder bit indices and class masks for the instruction sequencer.
package seq_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEC_W    = 39;
  localparam int unsigned WB_SEL_W = 2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4
  } instr_class_e;

  // Decoder one-hot bit positions
  localparam int unsigned DEC_ADD    = 0;
  localparam int unsigned DEC_SUB    = 1;
  localparam int unsigned DEC_XOR    = 2;
  localparam int unsigned DEC_OR     = 3;
  localparam int unsigned DEC_AND    = 4;
  localparam int unsigned DEC_SLL    = 5;
  localparam int unsigned DEC_SRL    = 6;
  localparam int unsigned DEC_SRA    = 7;
  localparam int unsigned DEC_SLT    = 8;
  localparam int unsigned DEC_SLTU   = 9;
  localparam int unsigned DEC_ADDI   = 10;
  localparam int unsigned DEC_XORI   = 11;
  localparam int unsigned DEC_ORI    = 12;
  localparam int unsigned DEC_ANDI   = 13;
  localparam int unsigned DEC_SLLI   = 14;
  localparam int unsigned DEC_SRLI   = 15;
  localparam int unsigned DEC_SRAI   = 16;
  localparam int unsigned DEC_SLTI   = 17;
  localparam int unsigned DEC_SLTIU  = 18;
  localparam int unsigned DEC_LB     = 19;
  localparam int unsigned DEC_LH     = 20;
  localparam int unsigned DEC_LW     = 21;
  localparam int unsigned DEC_LBU    = 22;
  localparam int unsigned DEC_LHU    = 23;
  localparam int unsigned DEC_SB     = 24;
  localparam int unsigned DEC_SH     = 25;
  localparam int unsigned DEC_SW     = 26;
  localparam int unsigned DEC_BEQ    = 27;
  localparam int unsigned DEC_BNE    = 28;
  localparam int unsigned DEC_BLT    = 29;
  localparam int unsigned DEC_BGE    = 30;
  localparam int unsigned DEC_BLTU   = 31;
  localparam int unsigned DEC_BGEU   = 32;
  localparam int unsigned DEC_JAL    = 33;
  localparam int unsigned DEC_JALR   = 34;
  localparam int unsigned DEC_LUI    = 35;
  localparam int unsigned DEC_AUIPC  = 36;
  localparam int unsigned DEC_ECALL  = 37;
  localparam int unsigned DEC_EBREAK = 38;

  // Class masks over the one-hot vector
  localparam logic [DEC_W-1:0] MEM_MASK    = 39'h00_07F8_0000; // 19..26
  localparam logic [DEC_W-1:0] STORE_MASK  = 39'h00_0700_0000; // 24..26
  localparam logic [DEC_W-1:0] BRANCH_MASK = 39'h01_F800_0000; // 27..32
  localparam logic [DEC_W-1:0] JUMP_MASK   = 39'h06_0000_0000; // 33..34
  localparam logic [DEC_W-1:0] HALT_MASK   = 39'h60_0000_0000; // 37..38

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [WB_SEL_W-1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic         halt;
    logic         illegal;
    instr_class_e cls;
  } dec_class_t;

  // Priority classification: halt > illegal > mem > branch > jump > alu
  function automatic dec_class_t classify(input logic [DEC_W-1:0] dec);
    dec_class_t r;
    r.halt    = |(dec & HALT_MASK);
    r.illegal = (dec == '0);
    r.cls     = CLS_ALU;
    if (|(dec & MEM_MASK)) begin
      r.cls = (|(dec & STORE_MASK)) ? CLS_STORE : CLS_LOAD;
    end else if (|(dec & BRANCH_MASK)) begin
      r.cls = CLS_BRANCH;
    end else if (|(dec & JUMP_MASK)) begin
      r.cls = CLS_JUMP;
    end
    return r;
  endfunction

  // Writeback source for a given class
  function automatic logic [WB_SEL_W-1:0] wb_sel_for(input instr_class_e cls);
    logic [WB_SEL_W-1:0] s;
    s = WB_SEL_ALU;
    if (cls == CLS_LOAD) s = WB_SEL_LOAD;
    else if (cls == CLS_JUMP) s = WB_SEL_PC4;
    return s;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bus-ack wait counter with expiry flag, shared by the fetch and data-access waits.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Count waited cycles; saturate at the expiry value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback control FSM for the RV32I core.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [38:0] dec_signal,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] pc,
  output logic [31:0] retired_cnt,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  seq_state_e   state_q, state_d;
  instr_class_e cls_q, cls_d;
  dec_class_t   dec_cls_c;

  logic [XLEN-1:0] pc_d, instr_d, retired_d;
  logic [XLEN-1:0] pc_plus4_c, retired_inc_c;
  logic            halted_d, illegal_d, bus_err_d;
  logic            tmr_clr_c, tmr_inc_c, tmr_expired_c;
  logic            target_misaligned_c;

  assign dec_cls_c           = classify(dec_signal);
  assign pc_plus4_c          = pc + XLEN'(4);
  assign retired_inc_c       = retired_cnt + XLEN'(1);
  assign target_misaligned_c = |target_addr[1:0];
  assign imem_addr           = pc;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr_c),
    .inc       (tmr_inc_c),
    .expired_c (tmr_expired_c)
  );

  // Next-state and architectural-state update
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pc_d      = pc;
    instr_d   = instr;
    retired_d = retired_cnt;
    halted_d  = halted;
    illegal_d = illegal;
    bus_err_d = bus_err;
    tmr_inc_c = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // The request strobe is registered, so nothing is accepted until it is up
        if (imem_req) begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            state_d = ST_DECODE;
          end else if (tmr_expired_c) begin
            bus_err_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            tmr_inc_c = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        if (dec_cls_c.halt) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (dec_cls_c.illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cls_d   = dec_cls_c.cls;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            if (branch_taken && target_misaligned_c) begin
              illegal_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              pc_d      = branch_taken ? target_addr : pc_plus4_c;
              retired_d = retired_inc_c;
              state_d   = ST_FETCH;
            end
          end
          CLS_JUMP: begin
            if (target_misaligned_c) begin
              illegal_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              state_d = ST_WB;
            end
          end
          default: state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        if (dmem_req) begin
          if (dmem_ack) begin
            if (cls_q == CLS_STORE) begin
              pc_d      = pc_plus4_c;
              retired_d = retired_inc_c;
              state_d   = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (tmr_expired_c) begin
            bus_err_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            tmr_inc_c = 1'b1;
          end
        end
      end

      ST_WB: begin
        pc_d      = (cls_q == CLS_JUMP) ? target_addr : pc_plus4_c;
        retired_d = retired_inc_c;
        state_d   = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_HALT;
    endcase

    // Any state change restarts the wait budget for the next bus wait
    tmr_clr_c = (state_d != state_q);
  end

  // State register plus strobes registered from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      cls_q       <= CLS_ALU;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      retired_cnt <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      imem_req    <= 1'b0;
      alu_en      <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      rf_we       <= 1'b0;
      wb_sel      <= WB_SEL_ALU;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      pc          <= pc_d;
      instr       <= instr_d;
      retired_cnt <= retired_d;
      halted      <= halted_d;
      illegal     <= illegal_d;
      bus_err     <= bus_err_d;
      imem_req    <= (state_d == ST_FETCH);
      alu_en      <= (state_d == ST_EXEC);
      dmem_req    <= (state_d == ST_MEM);
      dmem_we     <= (state_d == ST_MEM) && (cls_d == CLS_STORE);
      rf_we       <= (state_d == ST_WB);
      wb_sel      <= (state_d == ST_WB) ? wb_sel_for(cls_d) : WB_SEL_ALU;
    end
  end

endmodule
